// File: rtl/seq_left_shifter.sv
// seq_left_shifter: multi-cycle left shifter, one bit position per clock under start/busy/done.
//   Modes: 00 logical left, 01 arithmetic left (sticky overflow), 10 rotate left, 11 pass.
//   Ports: clk, rst (async active-low), start, mode[1:0], shamt[SHW-1:0], din[WIDTH-1:0]
//          -> dout[WIDTH-1:0], carry, ovf, busy, done (one-cycle pulse).
//   Optional: define LSHIFT_SAT_EN to saturate dout in mode 01 when ovf is set.
module seq_left_shifter #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             carry,
    output logic             ovf,
    output logic             busy,
    output logic             done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    logic [1:0]       state;
    logic [1:0]       mode_r;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] step;
    // rotate feeds the outgoing MSB back into bit 0; other modes shift in zero
    assign step = {dout[WIDTH-2:0], (mode_r == 2'b10) & dout[WIDTH-1]};
`ifdef LSHIFT_SAT_EN
    logic             sign_r;
    logic [WIDTH-1:0] sat;
    // most positive / most negative value, chosen by the original operand's sign
    assign sat = {sign_r, {(WIDTH-1){~sign_r}}};
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            mode_r <= 2'b00;
            cnt    <= '0;
            dout   <= '0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef LSHIFT_SAT_EN
            sign_r <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    dout   <= din;
                    mode_r <= mode;
                    cnt    <= shamt;
                    carry  <= 1'b0;
                    ovf    <= 1'b0;
                    busy   <= 1'b1;
                    state  <= (shamt != '0 && mode != 2'b11) ? SHIFT : DONE;
`ifdef LSHIFT_SAT_EN
                    sign_r <= din[WIDTH-1];
`endif
                end
                SHIFT: begin
                    carry <= dout[WIDTH-1];
                    dout  <= step;
                    // a step that changes the sign bit means the signed value no longer fits
                    ovf   <= ovf | ((mode_r == 2'b01) & (dout[WIDTH-1] ^ dout[WIDTH-2]));
                    cnt   <= cnt - 1'b1;
                    state <= (cnt == SHW'(1)) ? DONE : SHIFT;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
`ifdef LSHIFT_SAT_EN
                    if (mode_r == 2'b01 && ovf)
                        dout <= sat;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
